// File: rtl/store_queue_if.sv
// Store-queue bus bundle: enqueue port from the memory pipe
// and drain port toward the data cache write side.
interface store_queue_if;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;

  modport master (
    output st_valid, st_addr, st_wdata, st_wstrb, mem_ready,
    input  st_ready, mem_req, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    input  st_valid, st_addr, st_wdata, st_wstrb, mem_ready,
    output st_ready, mem_req, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/store_queue.sv
// In-order store queue: speculative enqueue, in-order commit,
// one-per-cycle drain to dcache, flush drops uncommitted stores.
module store_queue #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  store_queue_if.slave sq,
  input  logic        commit_store1_valid,
  input  logic        commit_store2_valid,
  input  logic [31:0] ld_addr,
  input  logic [3:0]  ld_strb,
  output logic        ld_conflict,
  output logic        sq_empty
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0] head, cmt, tail;
  logic [PW-1:0] count, cmt_next;
  logic [1:0]    ncmt;
  logic          full, enq, drain;

  logic [31:0] addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [3:0]  strb_q [DEPTH];

  assign count    = tail - head;
  assign full     = (count == PW'(DEPTH));
  assign sq_empty = (head == tail);

  assign sq.st_ready = !full && !flush;
  assign enq         = sq.st_valid && sq.st_ready;

  assign sq.mem_req   = (head != cmt);
  assign drain        = sq.mem_req && sq.mem_ready;
  assign sq.mem_addr  = sq.mem_req ? addr_q[head[IW-1:0]] : '0;
  assign sq.mem_wdata = sq.mem_req ? data_q[head[IW-1:0]] : '0;
  assign sq.mem_wstrb = sq.mem_req ? strb_q[head[IW-1:0]] : '0;

  assign ncmt = {1'b0, commit_store1_valid}
              + {1'b0, commit_store2_valid};
  assign cmt_next = cmt + PW'(ncmt);

  // Flush sees this cycle's commits, so tail snaps to cmt_next
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      cmt  <= '0;
      tail <= '0;
    end else begin
      head <= head + PW'(drain);
      cmt  <= cmt_next;
      tail <= flush ? cmt_next : tail + PW'(enq);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail[IW-1:0]] <= sq.st_addr;
      data_q[tail[IW-1:0]] <= sq.st_wdata;
      strb_q[tail[IW-1:0]] <= sq.st_wstrb;
    end
  end

  logic [IW-1:0] off;

  // An entry is live when its distance from head is below count
  always_comb begin
    ld_conflict = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = IW'(i) - head[IW-1:0];
      if (({1'b0, off} < count)
          && (addr_q[i][31:2] == ld_addr[31:2])
          && (|(strb_q[i] & ld_strb)))
        ld_conflict = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(commit_store2_valid && !commit_store1_valid));
      assert (PW'(ncmt) <= (tail - cmt));
    end
  end
endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: drain timing, full/backpressure,
// flush, load conflict, wrap traffic and mid-drain reset.
module tb_store_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        c1, c2;
  logic [31:0] ld_addr;
  logic [3:0]  ld_strb;
  logic        ld_conflict;
  logic        sq_empty;

  int checks = 0;
  int failures = 0;

  store_queue_if sq();

  store_queue #(.DEPTH(8)) dut (
    .clk                 (clk),
    .reset               (reset),
    .flush               (flush),
    .sq                  (sq),
    .commit_store1_valid (c1),
    .commit_store2_valid (c2),
    .ld_addr             (ld_addr),
    .ld_strb             (ld_strb),
    .ld_conflict         (ld_conflict),
    .sq_empty            (sq_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [3:0] s);
    sq.st_valid = 1'b1;
    sq.st_addr  = a;
    sq.st_wdata = d;
    sq.st_wstrb = s;
    #1;
    chk("enq_ready", {31'b0, sq.st_ready}, 32'd1);
    tick();
    sq.st_valid = 1'b0;
  endtask

  logic [31:0] exp_addr [40];
  logic [31:0] exp_data [40];

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    c1 = 1'b0;
    c2 = 1'b0;
    ld_addr = '0;
    ld_strb = '0;
    sq.st_valid = 1'b0;
    sq.st_addr = '0;
    sq.st_wdata = '0;
    sq.st_wstrb = '0;
    sq.mem_ready = 1'b0;
    #1;
    chk("rst_req", {31'b0, sq.mem_req}, 32'd0);
    chk("rst_empty", {31'b0, sq_empty}, 32'd1);
    chk("rst_ready", {31'b0, sq.st_ready}, 32'd1);
    chk("rst_addr", sq.mem_addr, 32'd0);
    chk("rst_ldc", {31'b0, ld_conflict}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;

    // single store: commit then drain one cycle later
    enq(32'h100, 32'hDEADBEEF, 4'hF);
    c1 = 1'b1;
    #1;
    chk("t1_req_pre", {31'b0, sq.mem_req}, 32'd0);
    tick();
    c1 = 1'b0;
    sq.mem_ready = 1'b1;
    #1;
    chk("t1_req", {31'b0, sq.mem_req}, 32'd1);
    chk("t1_addr", sq.mem_addr, 32'h100);
    chk("t1_data", sq.mem_wdata, 32'hDEADBEEF);
    chk("t1_strb", {28'b0, sq.mem_wstrb}, 32'hF);
    tick();
    chk("t1_empty", {31'b0, sq_empty}, 32'd1);
    chk("t1_req_post", {31'b0, sq.mem_req}, 32'd0);

    // fill to full, commit two, hold then release
    sq.mem_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      enq(32'h200 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
    sq.st_valid = 1'b1;
    sq.st_addr = 32'h999;
    #1;
    chk("t2_full", {31'b0, sq.st_ready}, 32'd0);
    chk("t2_noreq", {31'b0, sq.mem_req}, 32'd0);
    tick();
    sq.st_valid = 1'b0;
    c1 = 1'b1;
    c2 = 1'b1;
    tick();
    c1 = 1'b0;
    c2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_hold_req", {31'b0, sq.mem_req}, 32'd1);
      chk("t2_hold_addr", sq.mem_addr, 32'h200);
      chk("t2_hold_data", sq.mem_wdata, 32'hA000_0000);
      tick();
    end
    sq.mem_ready = 1'b1;
    #1;
    chk("t2_d0", sq.mem_addr, 32'h200);
    tick();
    chk("t2_d1", sq.mem_addr, 32'h204);
    chk("t2_d1data", sq.mem_wdata, 32'hA000_0001);
    tick();
    chk("t2_stop", {31'b0, sq.mem_req}, 32'd0);
    chk("t2_spec", {31'b0, sq_empty}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("t2_flushed", {31'b0, sq_empty}, 32'd1);

    // flush with a same-cycle commit keeps two stores
    sq.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      enq(32'h300 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'hF);
    c1 = 1'b1;
    tick();
    flush = 1'b1;
    sq.mem_ready = 1'b1;
    #1;
    chk("t3_blocked", {31'b0, sq.st_ready}, 32'd0);
    chk("t3_d0", sq.mem_addr, 32'h300);
    tick();
    c1 = 1'b0;
    flush = 1'b0;
    #1;
    chk("t3_d1req", {31'b0, sq.mem_req}, 32'd1);
    chk("t3_d1", sq.mem_addr, 32'h304);
    tick();
    chk("t3_done", {31'b0, sq.mem_req}, 32'd0);
    chk("t3_empty", {31'b0, sq_empty}, 32'd1);

    // load overlap probe
    sq.mem_ready = 1'b0;
    enq(32'h106, 32'h1, 4'hC);
    ld_addr = 32'h104;
    ld_strb = 4'h3;
    #1;
    chk("t4_nolap", {31'b0, ld_conflict}, 32'd0);
    ld_strb = 4'h4;
    #1;
    chk("t4_lap_c", {31'b0, ld_conflict}, 32'd1);
    ld_strb = 4'h3;
    enq(32'h105, 32'h2, 4'h2);
    #1;
    chk("t4_lap_2", {31'b0, ld_conflict}, 32'd1);
    ld_addr = 32'h108;
    #1;
    chk("t4_other", {31'b0, ld_conflict}, 32'd0);
    ld_addr = 32'h104;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("t4_flushed", {31'b0, ld_conflict}, 32'd0);

    // 40 stores across pointer wrap with random backpressure
    begin
      int k = 0;
      int drained = 0;
      int pend = 0;
      int cyc = 0;
      int ncm;
      logic acc;
      for (int i = 0; i < 40; i++) begin
        exp_addr[i] = 32'h1000 + 32'(4 * i);
        exp_data[i] = $urandom;
      end
      while (drained < 40 && cyc < 2000) begin
        ncm = $urandom_range(0, 2);
        if (ncm > pend) ncm = pend;
        c1 = (ncm >= 1);
        c2 = (ncm == 2);
        pend -= ncm;
        sq.mem_ready = 1'($urandom_range(0, 1));
        sq.st_valid = (k < 40);
        if (k < 40) begin
          sq.st_addr = exp_addr[k];
          sq.st_wdata = exp_data[k];
          sq.st_wstrb = 4'hF;
        end
        #1;
        acc = sq.st_valid && sq.st_ready;
        if (sq.mem_req && sq.mem_ready) begin
          chk("t5_addr", sq.mem_addr, exp_addr[drained]);
          chk("t5_data", sq.mem_wdata, exp_data[drained]);
          drained++;
        end
        tick();
        if (acc) begin
          k++;
          pend++;
        end
        cyc++;
      end
      c1 = 1'b0;
      c2 = 1'b0;
      sq.st_valid = 1'b0;
      chk("t5_count", 32'(drained), 32'd40);
      #1;
      chk("t5_empty", {31'b0, sq_empty}, 32'd1);
    end

    // reset during a stalled drain
    sq.mem_ready = 1'b0;
    enq(32'h400, 32'h5, 4'hF);
    c1 = 1'b1;
    tick();
    c1 = 1'b0;
    #1;
    chk("t6_req", {31'b0, sq.mem_req}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_req_rst", {31'b0, sq.mem_req}, 32'd0);
    chk("t6_empty_rst", {31'b0, sq_empty}, 32'd1);
    chk("t6_addr_rst", sq.mem_addr, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("t6_req_post", {31'b0, sq.mem_req}, 32'd0);
    chk("t6_empty_post", {31'b0, sq_empty}, 32'd1);
    chk("t6_ready_post", {31'b0, sq.st_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
